mult_seq: RTL
=============

MULT_SEQ -- requirements
Module: mult_seq

Parameters
REQ-001 The block SHALL have parameter N, default 8, giving the multiplicand (mult1) width in bits, with N >= 2.
REQ-002 The block SHALL have parameter M, default 4, giving the multiplier (mult2) width in bits, with M >= 2.
REQ-003 The block SHALL have parameter EARLY_EXIT, default 0; when 1, the block terminates once no set multiplier bits remain.

Interface
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operands and mode present.
REQ-007 in_ready  out  1  block can accept an operation.
REQ-008 mult1  in  N  multiplicand.
REQ-009 mult2  in  M  multiplier.
REQ-010 sgn  in  1  1 = both operands two's complement, 0 = both unsigned.
REQ-011 out_valid  out  1  res holds a completed product.
REQ-012 out_ready  in  1  consumer accepts res.
REQ-013 res  out  N+M  product.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE, and out_valid SHALL be 1 exactly in DONE; both SHALL be registered-state decodes.
REQ-016 Accept SHALL occur on an edge with in_valid=1 in IDLE; that edge latches the operands and sign mode, clears the accumulator and bit counter, and enters CALC.
REQ-017 In unsigned mode, the accept edge SHALL latch mult1 and mult2 as magnitudes.
REQ-018 In signed mode, the accept edge SHALL latch |mult1|, |mult2| and neg = sign(mult1) XOR sign(mult2); the N-bit unsigned magnitude SHALL hold 2^(N-1) for mult1 = -2^(N-1), and likewise for M.
REQ-019 Each CALC edge SHALL add (mcand << cnt) to the (N+M)-bit accumulator if the current multiplier LSB is 1, then shift the multiplier right by 1 and increment cnt.
REQ-020 With EARLY_EXIT=0, the edge processing bit M-1 SHALL enter DONE, so out_valid rises exactly M edges after the accept edge.
REQ-021 With EARLY_EXIT=1, the first CALC edge after which the shifted multiplier is zero SHALL enter DONE, giving a latency of max(1, index of the highest set magnitude bit + 1) edges.
REQ-022 With EARLY_EXIT=1 and a zero multiplier magnitude, latency SHALL be 1 edge and res SHALL be 0.
REQ-023 On the DONE-entry edge, res SHALL be loaded with neg ? -(acc_next) : acc_next, modulo 2^(N+M); the full product always fits.
REQ-024 res SHALL be held stable throughout DONE.
REQ-025 res SHALL keep its last value in IDLE and CALC (not cleared).
REQ-026 A DONE edge with out_ready=1 SHALL return the FSM to IDLE.
REQ-027 No new operation SHALL be accepted until the edge after the result is consumed (no overlap).
REQ-028 A DONE edge with out_ready=0 SHALL leave the FSM in DONE indefinitely; back-pressure has no timeout.
REQ-029 In CALC, the block SHALL ignore in_valid, mult1, mult2 and sgn.
REQ-030 Operand changes after the accept edge SHALL NOT affect the result.
REQ-031 out_ready SHALL be ignored outside DONE.

Reset
REQ-032 An edge with rst=1 SHALL force IDLE and set in_ready=1, out_valid=0, res=0, and the accumulator, counter and neg to 0, regardless of state.
REQ-033 rst SHALL take priority over accept and consume on the same edge.
REQ-034 An operation in flight during reset SHALL be discarded with no out_valid.

Verification (N=8, M=4)
REQ-035 Unsigned, EARLY_EXIT=0: mult1=25, mult2=5, sgn=0, out_ready=1 -> out_valid 4 edges after accept, res=125, in_ready 1 the next cycle.
REQ-036 Unsigned max: 255 x 15 -> res=3825 (12'hEF1).
REQ-037 Unsigned mixed values: 215 x 9 -> res=1935.
REQ-038 Signed: -3 x 5 -> res=12'hFF1 (-15).
REQ-039 Signed extremes: -128 x -8 -> res=1024; 127 x -8 -> 12'hC08 (-1016).
REQ-040 Back-pressure: 16 x 10 with out_ready held 0 for 3 cycles after out_valid -> res=160 stable, in_ready=0 and in_valid ignored throughout, return to IDLE on the edge where out_ready=1.
REQ-041 Reset mid-operation: assert rst 2 edges after accept of 10 x 4 -> IDLE, out_valid never rises; next operation 13 x 5 -> res=65.
REQ-042 EARLY_EXIT=1: mult2=1 -> out_valid 1 edge after accept.
REQ-043 EARLY_EXIT=1: mult2=0 -> res=0, latency 1 edge.
REQ-044 EARLY_EXIT=1: mult2=4 -> latency 3 edges.
REQ-045 All verification cases SHALL be compared against a reference product computed in the bench.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier with optional signed operands and an
// optional early exit once no set multiplier bits remain.
module mult_seq #(
  parameter int N          = 8,
  parameter int M          = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     mult1,
  input  logic [M-1:0]     mult2,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   res,
  output logic [1:0]       dbg_state_o
);

  localparam int W  = N + M;
  localparam int CW = (M > 2) ? $clog2(M) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: an input transfer happens on an edge where in_valid && in_ready;
  // an output transfer happens on an edge where out_valid && out_ready.
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [M-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  res_q, res_d;

  logic [N-1:0]  mag1;
  logic [M-1:0]  mag2;
  logic [W-1:0]  add_term;
  logic [W-1:0]  acc_next;
  logic [M-1:0]  mplier_next;
  logic          last_bit;

  // Two's-complement negation of the most negative value yields 2^(K-1) as
  // an unsigned K-bit magnitude, which is exactly what is wanted.
  always_comb begin
    mag1        = (sgn && mult1[N-1]) ? (~mult1 + N'(1)) : mult1;
    mag2        = (sgn && mult2[M-1]) ? (~mult2 + M'(1)) : mult2;
    add_term    = W'(mcand_q) << cnt_q;
    acc_next    = acc_q + (mplier_q[0] ? add_term : '0);
    mplier_next = mplier_q >> 1;
    last_bit    = (EARLY_EXIT != 0) ? (mplier_next == '0) : (cnt_q == CW'(M - 1));
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = sgn & (mult1[N-1] ^ mult2[M-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_next;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          res_d   = neg_q ? (-acc_next) : acc_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign res         = res_q;
  assign dbg_state_o = state_q;

endmodule
